// File: rtl/round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : round_ctrl
//  Purpose  : Match sequencer for the two-player game. Detects kills on the
//             player health buses, strobes the BCD score counters, holds the
//             respawn freeze and decides between continuing play and ending
//             the match.
//  Revision : 1.0 - initial release
//
//  Parameters
//    WIN_SCORE       kills needed to win (1..99)
//    RESPAWN_FRAMES  frame ticks spent in the respawn freeze (1..255)
//
//  Ports
//    Clk                       in   system clock
//    Reset_n                   in   asynchronous active-low reset
//    frame_tick                in   one-cycle pulse per video frame
//    start                     in   start button level (edge detected here)
//    p1_health, p2_health      in   [9:0] player health, 0 = dead
//    p1_digit_1/2, p2_digit_1/2 in  [3:0] BCD score digits (1 = ones, 2 = tens)
//    score_inc_p1/p2           out  one-cycle increment strobes
//    score_clr                 out  one-cycle clear strobe to both counters
//    respawn                   out  one-cycle health restore strobe
//    freeze                    out  1 = movement and attacks disabled
//    game_state                out  [1:0] 00 IDLE, 01 PLAY, 10 KILLED/SCORE/CHECK, 11 OVER
//    winner                    out  [1:0] 00 none, 01 P1, 10 P2, 11 draw
//
//  Build option
//    ROUND_CTRL_TIE_BREAK_EN   when defined, equal scores never end the match
//                              and a draw (winner = 11) is never reported.
// ============================================================================
module round_ctrl #(
  parameter int WIN_SCORE      = 10,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] p1_health,
  input  logic [9:0] p2_health,
  input  logic [3:0] p1_digit_1,
  input  logic [3:0] p1_digit_2,
  input  logic [3:0] p2_digit_1,
  input  logic [3:0] p2_digit_2,
  output logic       score_inc_p1,
  output logic       score_inc_p2,
  output logic       score_clr,
  output logic       respawn,
  output logic       freeze,
  output logic [1:0] game_state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_SCORE  = 3'd2,
    S_CHECK  = 3'd3,
    S_KILLED = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  localparam logic [1:0] GS_IDLE   = 2'b00;
  localparam logic [1:0] GS_PLAY   = 2'b01;
  localparam logic [1:0] GS_ROUND  = 2'b10;
  localparam logic [1:0] GS_OVER   = 2'b11;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;

  localparam logic [7:0] C_WIN     = 8'(WIN_SCORE);
  localparam logic [7:0] C_RESPAWN = 8'(RESPAWN_FRAMES);

  // Tens digit can legally only reach 9, but the 8-bit result keeps
  // malformed BCD (up to 165) from wrapping into a small value.
  function automatic logic [7:0] bcd_value(input logic [3:0] tens,
                                           input logic [3:0] ones);
    return ({4'd0, tens} * 8'd10) + {4'd0, ones};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] countdown_q, countdown_d;
  logic       p1_armed_q, p1_armed_d;
  logic       p2_armed_q, p2_armed_d;
  logic       start_q, start_d;
  logic       score_inc_p1_q, score_inc_p1_d;
  logic       score_inc_p2_q, score_inc_p2_d;
  logic       score_clr_q, score_clr_d;
  logic       respawn_q, respawn_d;
  logic       freeze_q, freeze_d;
  logic [1:0] game_state_q, game_state_d;
  logic [1:0] winner_q, winner_d;

  logic       start_rise;
  logic       p1_dead, p2_dead;
  logic       kill_p1, kill_p2;
  logic [7:0] s1, s2;
  logic       p1_hit, p2_hit;
  logic       declare_win;
  logic [1:0] win_sel;

  assign start_rise = start & ~start_q;
  assign p1_dead    = (p1_health == 10'd0);
  assign p2_dead    = (p2_health == 10'd0);
  // kill_pN means player N died; the opponent gets the point.
  assign kill_p1    = (state_q == S_PLAY) & p1_dead & p1_armed_q;
  assign kill_p2    = (state_q == S_PLAY) & p2_dead & p2_armed_q;

  assign s1     = bcd_value(p1_digit_2, p1_digit_1);
  assign s2     = bcd_value(p2_digit_2, p2_digit_1);
  assign p1_hit = (s1 >= C_WIN);
  assign p2_hit = (s2 >= C_WIN);

`ifdef ROUND_CTRL_TIE_BREAK_EN
  // A tie at or above the target keeps the match running until one
  // player pulls ahead.
  assign declare_win = (p1_hit | p2_hit) & (s1 != s2);
  assign win_sel     = (s1 > s2) ? WIN_P1 : WIN_P2;
`else
  assign declare_win = p1_hit | p2_hit;
  assign win_sel     = {p2_hit, p1_hit};
`endif

  always_comb begin
    state_d        = state_q;
    countdown_d    = countdown_q;
    winner_d       = winner_q;
    start_d        = start;
    score_inc_p1_d = 1'b0;
    score_inc_p2_d = 1'b0;
    score_clr_d    = 1'b0;
    respawn_d      = 1'b0;

    // Arming on live health means a body lying at 0 is never re-counted.
    p1_armed_d = p1_armed_q;
    if (!p1_dead)     p1_armed_d = 1'b1;
    else if (kill_p1) p1_armed_d = 1'b0;

    p2_armed_d = p2_armed_q;
    if (!p2_dead)     p2_armed_d = 1'b1;
    else if (kill_p2) p2_armed_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise) begin
          score_clr_d = 1'b1;
          respawn_d   = 1'b1;
          winner_d    = WIN_NONE;
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        if (kill_p1 || kill_p2) begin
          score_inc_p1_d = kill_p2;
          score_inc_p2_d = kill_p1;
          state_d        = S_SCORE;
        end
      end
      S_SCORE: begin
        // Counters update on this edge; their digits are read in CHECK.
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (declare_win) begin
          winner_d = win_sel;
          state_d  = S_OVER;
        end else begin
          countdown_d = C_RESPAWN;
          state_d     = S_KILLED;
        end
      end
      S_KILLED: begin
        if (frame_tick) begin
          if (countdown_q == 8'd1) begin
            countdown_d = 8'd0;
            respawn_d   = 1'b1;
            state_d     = S_PLAY;
          end else begin
            countdown_d = countdown_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the next state so they change on the same
    // edge as the state itself.
    case (state_d)
      S_IDLE:  begin game_state_d = GS_IDLE;  freeze_d = 1'b1; end
      S_PLAY:  begin game_state_d = GS_PLAY;  freeze_d = 1'b0; end
      S_OVER:  begin game_state_d = GS_OVER;  freeze_d = 1'b1; end
      default: begin game_state_d = GS_ROUND; freeze_d = 1'b1; end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      countdown_q    <= 8'd0;
      p1_armed_q     <= 1'b0;
      p2_armed_q     <= 1'b0;
      start_q        <= 1'b0;
      score_inc_p1_q <= 1'b0;
      score_inc_p2_q <= 1'b0;
      score_clr_q    <= 1'b0;
      respawn_q      <= 1'b0;
      freeze_q       <= 1'b1;
      game_state_q   <= GS_IDLE;
      winner_q       <= WIN_NONE;
    end else begin
      state_q        <= state_d;
      countdown_q    <= countdown_d;
      p1_armed_q     <= p1_armed_d;
      p2_armed_q     <= p2_armed_d;
      start_q        <= start_d;
      score_inc_p1_q <= score_inc_p1_d;
      score_inc_p2_q <= score_inc_p2_d;
      score_clr_q    <= score_clr_d;
      respawn_q      <= respawn_d;
      freeze_q       <= freeze_d;
      game_state_q   <= game_state_d;
      winner_q       <= winner_d;
    end
  end

  assign score_inc_p1 = score_inc_p1_q;
  assign score_inc_p2 = score_inc_p2_q;
  assign score_clr    = score_clr_q;
  assign respawn      = respawn_q;
  assign freeze       = freeze_q;
  assign game_state   = game_state_q;
  assign winner       = winner_q;

endmodule
`default_nettype wire

// File: doc/round_ctrl.md
# round_ctrl

Match sequencer for the two-player game. Watches both players' health buses for a kill. On a kill it issues one-cycle increment pulses to the per-player BCD score counters and freezes play for a respawn delay. It then checks the counters' digits against the win score and either restarts play or ends the match. It sits between the player/health logic and the two score-digit counters, and drives the freeze and respawn strobes back to the player logic.

## Interface
- WIN_SCORE, 10: kills needed to win; legal range 1..99
- RESPAWN_FRAMES, 120: frame ticks spent in the respawn freeze; legal range 1..255
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  reset: asynchronous assert, active-low
- frame_tick  in  1  one-Clk pulse per video frame
- start  in  1  start button, level; rising edge detected internally
- p1_health, p2_health  in  10  current player health; 0 = dead
- p1_digit_1, p1_digit_2, p2_digit_1, p2_digit_2  in  4 each  score counter outputs, BCD; digit_1 = ones, digit_2 = tens
- score_inc_p1, score_inc_p2  out  1  one-cycle increment strobes to the score counters
- score_clr  out  1  one-cycle clear strobe to both counters
- respawn  out  1  one-cycle strobe; player logic restores health
- freeze  out  1  high = player movement and attacks disabled
- game_state  out  2  00 IDLE, 01 PLAY, 10 KILLED/SCORE/CHECK, 11 OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

## Operation
- All outputs are registered.
- Reset values: state IDLE, freeze=1, winner=00, game_state=00, all strobes=0, countdown=0, armed flags=0, start_q=0.
- Armed flag per player:
  - set on any cycle that player's health != 0;
  - cleared when a kill is taken.
  - A kill is therefore counted only on a nonzero-to-zero transition, never on a health value held at 0.
- States:
  - IDLE: freeze=1. On a start rising edge: pulse score_clr and respawn, set winner=00, go to PLAY.
  - PLAY: freeze=0. A kill is (p1_health==0 and p1 armed) or (p2_health==0 and p2 armed).
    - A dead P2 credits P1; a dead P1 credits P2.
    - On a kill: clear the dead player's armed flag, go to SCORE.
  - SCORE (1 cycle): freeze=1. score_inc_p1 and/or score_inc_p2 are high for this cycle only. Go to CHECK.
  - CHECK (1 cycle): compute s = 10*digit_2 + digit_1 per player.
    - If either s >= WIN_SCORE: set winner, go to OVER.
    - Otherwise: load countdown=RESPAWN_FRAMES, go to KILLED.
  - KILLED: freeze=1. Countdown decrements on each frame_tick.
    - When a frame_tick arrives with countdown==1: pulse respawn, go to PLAY.
  - OVER: freeze=1, winner held.
    - On a start rising edge: pulse score_clr and respawn, winner=00, go to PLAY.
- Simultaneous deaths in one cycle: both strobes fire in the same SCORE cycle.
- Start edges are ignored in PLAY, SCORE, CHECK and KILLED.
- The score counters saturate at 99. round_ctrl does not depend on their wrap behaviour.

## Timing
- Kill sampled in cycle N (PLAY):
  - score_inc high in cycle N+1 (SCORE);
  - counter digits valid in N+2 (CHECK);
  - state OVER or KILLED from N+3.
- Respawn latency is exactly RESPAWN_FRAMES frame_tick pulses after KILLED entry; respawn and the PLAY state change occur on the same edge.
- score_clr and respawn from IDLE/OVER assert the cycle after the start rising edge.
- freeze drops to 0 in the same cycle that game_state shows 01.
- Reset_n low at any time: all state returns to reset values immediately. Strobes in flight are dropped.

## Configuration
- ROUND_CTRL_TIE_BREAK_EN defined:
  - CHECK declares a winner only if max(s1,s2) >= WIN_SCORE and s1 != s2.
  - Equal scores at or above WIN_SCORE go to KILLED and play continues.
  - winner is never 11.
- Macro undefined:
  - Both players reaching >= WIN_SCORE in the same CHECK gives winner=11 (draw), then OVER.

## Test plan
- Reset, start rising edge -> score_clr and respawn pulse once, game_state=01, freeze=0.
- P2 health 50 -> 0 in PLAY (RESPAWN_FRAMES=3) -> score_inc_p1 one cycle, game_state=10, respawn after 3rd frame_tick, back to 01. Health held at 0 afterwards produces no second strobe.
- Counter at P1=09, WIN_SCORE=10, P2 killed -> digits become 1/0 in CHECK, state OVER, winner=01, freeze=1.
- Both at 9, both health -> 0 same cycle:
  - macro undefined -> winner=11, OVER;
  - macro defined -> KILLED, play resumes, next single kill gives 11-10, winner set accordingly.
- Reset_n pulsed low mid-KILLED -> immediate IDLE, freeze=1, winner=00, no respawn strobe.
- Start pressed during PLAY and KILLED -> no effect. Start in OVER -> score_clr, respawn, PLAY, winner=00.
